hamming_scrub_ctrl: RTL and testbench
=====================================

# hamming_scrub_ctrl

Controller that owns a single-port memory of Hamming(7,4) codewords and shares it between a host read port and a background scrubber. Each host read returns corrected 4-bit data plus error flags. A scrub pass walks every address, decodes each word, and writes single-bit corrections back. The block sits between the codeword RAM and the consumer, sequencing all RAM accesses.

## Interface
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin scrub pass (ignored while busy)
- host_req  in  1  host read request; held until host_gnt
- host_addr  in  ADDR_W  host read address, sampled with grant
- host_gnt  out  1  one-cycle pulse: host read issued to RAM
- host_rvalid  out  1  one-cycle pulse: host_rdata/host_err valid
- host_rdata  out  4  corrected data {d1,d2,d3,d4}
- host_err  out  1  nonzero syndrome on the host read
- mem_en, mem_we  out  1 each  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  7  RAM write data
- mem_rdata  in  7  RAM read data, valid the cycle after a read cycle (mem_en=1, mem_we=0)
- busy  out  1  scrub pass in progress
- done  out  1  one-cycle pulse at pass end
- err_count  out  ADDR_W+1  words corrected in the current or last pass
- last_err_addr  out  ADDR_W  address of the most recent scrub correction
- last_err_pos  out  3  syndrome of the most recent scrub correction

## Operation
- Codeword layout: cw[6]..cw[0] = positions 1..7 = p1 p2 d1 p4 d2 d3 d4.
- Syndrome: s1 = parity of positions 1,3,5,7; s2 = parity of positions 2,3,6,7; s4 = parity of positions 4,5,6,7; syn = {s4,s2,s1}.
- Correction: if syn != 0, flip cw[7-syn]. Data = {cw[4],cw[2],cw[1],cw[0]} after correction.
- Double-bit errors are miscorrected silently. This is accepted and not detected.
- FSM states: IDLE, S_RD, S_CHK, S_WB, S_NEXT, H_RD, H_CHK, DONE.
- mem_* outputs decode from the state register only:
  - Read states (mem_en=1, mem_we=0): S_RD and H_RD.
  - Write state (mem_en=1, mem_we=1): S_WB.
- IDLE:
  - host_req -> H_RD.
  - Otherwise start -> S_RD; this clears ptr, err_count and sets busy.
- S_RD -> S_CHK.
- S_CHK:
  - syn != 0 -> S_WB; latch the corrected word, err_count+1, last_err_addr=ptr, last_err_pos=syn.
  - syn == 0 -> S_NEXT.
- S_WB -> S_NEXT, writing the corrected word to ptr.
- S_NEXT:
  - ptr == DEPTH-1 -> DONE.
  - Otherwise ptr+1, then go to H_RD if host_req && !host_last, else S_RD.
- H_RD: host_gnt=1 and mem_addr=host_addr; sets host_last.
- H_CHK: registers host_rdata and host_err, pulses host_rvalid next cycle. Then returns to S_RD if busy, else IDLE.
- host_last clears on entering S_CHK. Host and scrub therefore alternate: at most one host read between scrubbed words, so neither side starves.
- Host reads never write back; only the scrubber repairs.
- DONE: done=1 and busy=0, then -> IDLE.

## Timing
- Reset: state IDLE, ptr 0, all outputs 0.
- Host read, idle controller:
  - host_req sampled at edge T.
  - host_gnt and mem read during cycle T+1.
  - host_rvalid high during T+3.
- Scrub word: 3 cycles if clean (S_RD, S_CHK, S_NEXT); 4 if corrected.
- Clean pass with no host traffic: done pulses 3*DEPTH+1 cycles after the start-sampling edge.
- start asserted together with host_req in IDLE: host wins; start is dropped and must be reissued.
- rst_n low mid-pass: immediate return to IDLE. Any in-flight write is aborted (mem_we drops asynchronously).
- err_count cannot overflow: max DEPTH fits in ADDR_W+1 bits.

## Test plan
- Reset mid-pass (during S_WB) -> all outputs 0 immediately, busy=0; a following start runs a full clean pass.
- Host read of addr 2 holding 0110011 -> host_rvalid 3 cycles after request, host_rdata=1011, host_err=0.
- Host read of 0100011 -> host_rdata=1011, host_err=1; RAM unchanged at 0100011.
- Scrub, ADDR_W=4:
  - Setup: all words 0110011 except addr 5 = 1010010 and addr 9 = 1111000.
  - Writes: 1011010 to addr 5, 1110000 to addr 9.
  - Result: err_count=2, last_err_addr=9, last_err_pos=4, done at cycle 3*16+2+1.
- host_req held high through a pass -> grants alternate with scrubbed words; pass completes; every host_rvalid carries correct data.
- start while busy -> ignored; err_count not cleared; single done pulse.

Source files
------------

// File: rtl/hamming_scrub_ctrl_if.sv
// Host read port of the Hamming(7,4) scrub controller: request/grant handshake
// plus the corrected read-data return path.
interface hamming_scrub_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic              host_gnt;
    logic              host_rvalid;
    logic [3:0]        host_rdata;
    logic              host_err;

    modport master (
        output host_req,
        output host_addr,
        input  host_gnt,
        input  host_rvalid,
        input  host_rdata,
        input  host_err
    );

    modport slave (
        input  host_req,
        input  host_addr,
        output host_gnt,
        output host_rvalid,
        output host_rdata,
        output host_err
    );
endinterface

// File: rtl/hamming_scrub_ctrl.sv
// Hamming(7,4) codeword RAM controller: arbitrates host reads against a background
// scrubber that walks every address and writes single-bit corrections back.
module hamming_scrub_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    hamming_scrub_ctrl_if.slave host,
    input  logic                start_i,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [6:0]          mem_wdata_o,
    input  logic [6:0]          mem_rdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W:0]     err_count_o,
    output logic [ADDR_W-1:0]   last_err_addr_o,
    output logic [2:0]          last_err_pos_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_WB   = 3'd3,
        S_NEXT = 3'd4,
        H_RD   = 3'd5,
        H_CHK  = 3'd6,
        DONE   = 3'd7
    } state_t;

    // cw[6]..cw[0] hold positions 1..7 = p1 p2 d1 p4 d2 d3 d4
    function automatic logic [2:0] syndrome(input logic [6:0] cw);
        logic s1;
        logic s2;
        logic s4;
        s1 = cw[6] ^ cw[4] ^ cw[2] ^ cw[0];
        s2 = cw[5] ^ cw[4] ^ cw[1] ^ cw[0];
        s4 = cw[3] ^ cw[2] ^ cw[1] ^ cw[0];
        return {s4, s2, s1};
    endfunction

    function automatic logic [6:0] correct(input logic [6:0] cw, input logic [2:0] syn);
        logic [6:0] c;
        c = cw;
        if (syn != 3'd0) begin
            c[3'd7 - syn] = ~cw[3'd7 - syn];
        end else begin
            c = cw;
        end
        return c;
    endfunction

    function automatic logic [3:0] data_of(input logic [6:0] cw);
        return {cw[4], cw[2], cw[1], cw[0]};
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              host_last_q, host_last_d;
    logic [6:0]        wb_q, wb_d;
    logic [ADDR_W:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0] last_err_addr_q, last_err_addr_d;
    logic [2:0]        last_err_pos_q, last_err_pos_d;
    logic [3:0]        rdata_q, rdata_d;
    logic              herr_q, herr_d;
    logic              rvalid_q, rvalid_d;
    logic [2:0]        syn_s;
    logic [6:0]        fixed_s;

    // Next-state and datapath updates for the arbitration/scrub FSM
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        busy_d          = busy_q;
        host_last_d     = host_last_q;
        wb_d            = wb_q;
        err_count_d     = err_count_q;
        last_err_addr_d = last_err_addr_q;
        last_err_pos_d  = last_err_pos_q;
        rdata_d         = rdata_q;
        herr_d          = herr_q;
        rvalid_d        = 1'b0;
        syn_s           = syndrome(mem_rdata_i);
        fixed_s         = correct(mem_rdata_i, syn_s);
        case (state_q)
            IDLE: begin
                if (host.host_req) begin
                    state_d = H_RD;
                end else if (start_i) begin
                    state_d     = S_RD;
                    ptr_d       = '0;
                    err_count_d = '0;
                    busy_d      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            S_RD: state_d = S_CHK;
            S_CHK: begin
                host_last_d = 1'b0;
                if (syn_s != 3'd0) begin
                    state_d         = S_WB;
                    wb_d            = fixed_s;
                    err_count_d     = err_count_q + (ADDR_W + 1)'(1);
                    last_err_addr_d = ptr_q;
                    last_err_pos_d  = syn_s;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WB: state_d = S_NEXT;
            S_NEXT: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (host.host_req && !host_last_q) begin
                        state_d = H_RD;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            H_RD: begin
                host_last_d = 1'b1;
                state_d     = H_CHK;
            end
            H_CHK: begin
                rdata_d  = data_of(fixed_s);
                herr_d   = (syn_s != 3'd0);
                rvalid_d = 1'b1;
                if (busy_q) begin
                    state_d = S_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            busy_q          <= 1'b0;
            host_last_q     <= 1'b0;
            wb_q            <= 7'd0;
            err_count_q     <= '0;
            last_err_addr_q <= '0;
            last_err_pos_q  <= 3'd0;
            rdata_q         <= 4'd0;
            herr_q          <= 1'b0;
            rvalid_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            busy_q          <= busy_d;
            host_last_q     <= host_last_d;
            wb_q            <= wb_d;
            err_count_q     <= err_count_d;
            last_err_addr_q <= last_err_addr_d;
            last_err_pos_q  <= last_err_pos_d;
            rdata_q         <= rdata_d;
            herr_q          <= herr_d;
            rvalid_q        <= rvalid_d;
        end
    end

    // RAM strobes decode from the state register alone so reset kills a write at once
    always_comb begin
        mem_en_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = ptr_q;
        host.host_gnt = 1'b0;
        done_o        = 1'b0;
        case (state_q)
            S_RD: mem_en_o = 1'b1;
            S_WB: begin
                mem_en_o = 1'b1;
                mem_we_o = 1'b1;
            end
            H_RD: begin
                mem_en_o      = 1'b1;
                mem_addr_o    = host.host_addr;
                host.host_gnt = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: mem_en_o = 1'b0;
        endcase
    end

    assign mem_wdata_o      = wb_q;
    assign busy_o           = busy_q;
    assign err_count_o      = err_count_q;
    assign last_err_addr_o  = last_err_addr_q;
    assign last_err_pos_o   = last_err_pos_q;
    assign host.host_rvalid = rvalid_q;
    assign host.host_rdata  = rdata_q;
    assign host.host_err    = herr_q;
endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed self-checking bench for hamming_scrub_ctrl with a behavioural codeword RAM.
module tb_hamming_scrub_ctrl;
    localparam int ADDR_W = 4;
    localparam logic [6:0] CLEAN = 7'b0110011;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [6:0]        mem_wdata;
    logic [6:0]        mem_rdata;
    logic              busy, done;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] last_err_addr;
    logic [2:0]        last_err_pos;

    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [6:0]        ld_data;
    logic [6:0]        mem [0:15];
    logic [ADDR_W-1:0] wr_addr_log [0:63];
    logic [6:0]        wr_data_log [0:63];
    int                wr_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;

    hamming_scrub_ctrl_if #(.ADDR_W(ADDR_W)) hif ();

    hamming_scrub_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host            (hif),
        .start_i         (start),
        .mem_en_o        (mem_en),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_rdata_i     (mem_rdata),
        .busy_o          (busy),
        .done_o          (done),
        .err_count_o     (err_count),
        .last_err_addr_o (last_err_addr),
        .last_err_pos_o  (last_err_pos)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with bench-side loader and write log
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            if (wr_cnt < 64) begin
                wr_addr_log[wr_cnt] <= mem_addr;
                wr_data_log[wr_cnt] <= mem_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [6:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic fill_clean();
        for (int i = 0; i < 16; i++) load(ADDR_W'(i), CLEAN);
    endtask

    // Runs until done; counts host grants and checks every rvalid in flight
    task automatic run_to_done(output int n, output int grants, output int rvalids);
        n = 0;
        grants = 0;
        rvalids = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            n++;
            if (hif.host_gnt) grants++;
            if (hif.host_rvalid) begin
                rvalids++;
                chk("pass_rdata", {28'd0, hif.host_rdata}, 32'hB);
                chk("pass_herr", {31'd0, hif.host_err}, 32'd0);
            end
            if (done) break;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n, g, rv, w0, dones;
        rst_n = 1'b0;
        start = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        hif.host_req = 1'b0;
        hif.host_addr = '0;
        fill_clean();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_err_count", {27'd0, err_count}, 32'd0);
        chk("rst_rvalid", {31'd0, hif.host_rvalid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Host read of a clean word
        hif.host_addr = 4'd2;
        hif.host_req = 1'b1;
        tick();
        chk("h1_gnt", {31'd0, hif.host_gnt}, 32'd1);
        chk("h1_mem_addr", {28'd0, mem_addr}, 32'd2);
        chk("h1_mem_we", {31'd0, mem_we}, 32'd0);
        hif.host_req = 1'b0;
        tick();
        chk("h1_rvalid_early", {31'd0, hif.host_rvalid}, 32'd0);
        tick();
        chk("h1_rvalid", {31'd0, hif.host_rvalid}, 32'd1);
        chk("h1_rdata", {28'd0, hif.host_rdata}, 32'hB);
        chk("h1_err", {31'd0, hif.host_err}, 32'd0);
        tick();
        chk("h1_rvalid_pulse", {31'd0, hif.host_rvalid}, 32'd0);

        // Host read of a single-bit-error word: corrected data, RAM untouched
        load(4'd7, 7'b0100011);
        w0 = wr_cnt;
        hif.host_addr = 4'd7;
        hif.host_req = 1'b1;
        tick();
        hif.host_req = 1'b0;
        tick();
        tick();
        chk("h2_rvalid", {31'd0, hif.host_rvalid}, 32'd1);
        chk("h2_rdata", {28'd0, hif.host_rdata}, 32'hB);
        chk("h2_err", {31'd0, hif.host_err}, 32'd1);
        tick();
        chk("h2_no_write", wr_cnt - w0, 32'd0);
        chk("h2_ram_kept", {25'd0, mem[7]}, {25'd0, 7'b0100011});
        load(4'd7, CLEAN);

        // Scrub with two corrections
        load(4'd5, 7'b1010010);
        load(4'd9, 7'b1111000);
        w0 = wr_cnt;
        pulse_start();
        chk("sc_busy", {31'd0, busy}, 32'd1);
        run_to_done(n, g, rv);
        chk("sc_done_cycle", n, 32'd50);
        chk("sc_busy_done", {31'd0, busy}, 32'd0);
        chk("sc_err_count", {27'd0, err_count}, 32'd2);
        chk("sc_last_addr", {28'd0, last_err_addr}, 32'd9);
        chk("sc_last_pos", {29'd0, last_err_pos}, 32'd4);
        tick();
        chk("sc_done_pulse", {31'd0, done}, 32'd0);
        chk("sc_writes", wr_cnt - w0, 32'd2);
        chk("sc_wr0_addr", {28'd0, wr_addr_log[w0]}, 32'd5);
        chk("sc_wr0_data", {25'd0, wr_data_log[w0]}, {25'd0, 7'b1011010});
        chk("sc_wr1_addr", {28'd0, wr_addr_log[w0 + 1]}, 32'd9);
        chk("sc_wr1_data", {25'd0, wr_data_log[w0 + 1]}, {25'd0, 7'b1110000});

        // Host held high through a pass: one grant between scrubbed words
        load(4'd9, 7'b1111000);
        start = 1'b1;
        tick();
        start = 1'b0;
        hif.host_addr = 4'd3;
        hif.host_req = 1'b1;
        run_to_done(n, g, rv);
        hif.host_req = 1'b0;
        chk("hh_done_cycle", n, 32'd79);
        chk("hh_grants", g, 32'd15);
        chk("hh_rvalids", rv, 32'd15);
        chk("hh_err_count", {27'd0, err_count}, 32'd1);
        tick();
        tick();
        chk("hh_ram_fixed", {25'd0, mem[9]}, {25'd0, 7'b1110000});

        // start while busy is ignored
        load(4'd4, 7'b0100011);
        pulse_start();
        for (int i = 0; i < 20; i++) tick();
        pulse_start();
        chk("sb_err_kept", {27'd0, err_count}, 32'd1);
        chk("sb_busy", {31'd0, busy}, 32'd1);
        dones = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (done) dones++;
        end
        chk("sb_done_pulses", dones, 32'd1);
        chk("sb_err_count", {27'd0, err_count}, 32'd1);
        chk("sb_busy_end", {31'd0, busy}, 32'd0);

        // Reset during the write-back state
        load(4'd5, 7'b1010010);
        w0 = wr_cnt;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (mem_we) break;
            tick();
        end
        chk("rs_in_wb", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rs_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rs_mem_wdata", {25'd0, mem_wdata}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_err_count", {27'd0, err_count}, 32'd0);
        chk("rs_last_addr", {28'd0, last_err_addr}, 32'd0);
        chk("rs_last_pos", {29'd0, last_err_pos}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rs_write_aborted", wr_cnt - w0, 32'd0);
        chk("rs_ram_kept", {25'd0, mem[5]}, {25'd0, 7'b1010010});

        // Following clean pass
        load(4'd5, CLEAN);
        w0 = wr_cnt;
        pulse_start();
        run_to_done(n, g, rv);
        chk("cp_done_cycle", n, 32'd48);
        chk("cp_err_count", {27'd0, err_count}, 32'd0);
        chk("cp_writes", wr_cnt - w0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
